// File: rtl/dram_line_xfer.sv
// Bridge from 256-bit cache-line requests to the two-beat 128-bit memory-controller protocol.
// Exactly one transaction is in flight; a read gives up after a bounded wait for its beats.
package dram_line_xfer_pkg;
    typedef struct packed {
        logic clk;
    } iu_clk_type;
endpackage

module dram_line_xfer
    import dram_line_xfer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  iu_clk_type    gclk,
    input  logic          rst,
    input  logic          req_val,
    output logic          req_rdy,
    input  logic          req_rw,
    input  logic [25:0]   req_addr,
    input  logic [255:0]  req_data,
    output logic          resp_val,
    input  logic          resp_rdy,
    output logic [255:0]  resp_data,
    output logic          mem_req_val,
    output logic          mem_req_rw,
    output logic [25:0]   mem_req_addr,
    output logic [127:0]  mem_req_data,
    input  logic          mem_req_rdy,
    input  logic          mem_resp_val,
    input  logic [127:0]  mem_resp_data,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_REQ, RD_B0, RD_B1, RESP
    } state_e;

    localparam logic [11:0] TMO_LIMIT = 12'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [25:0]   addr_q, addr_d;
    logic [255:0]  line_q, line_d;
    logic [11:0]   wait_q, wait_d;
    logic          tmo_q, tmo_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_d       = line_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        req_rdy      = 1'b0;
        resp_val     = 1'b0;
        resp_data    = '0;
        mem_req_val  = 1'b0;
        mem_req_rw   = 1'b0;
        mem_req_addr = (state_q == IDLE) ? '0 : addr_q;
        mem_req_data = '0;

        unique case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    addr_d  = req_addr;
                    line_d  = req_rw ? req_data : '0;
                    state_d = req_rw ? WR_LO : RD_REQ;
                end
            end
            // Write beats are qualified by rdy (and suppressed in reset) because the
            // controller counts val&rw whether or not it is ready.
            WR_LO: begin
                mem_req_val  = mem_req_rdy & ~rst;
                mem_req_rw   = 1'b1;
                mem_req_data = line_q[127:0];
                if (mem_req_rdy) state_d = WR_HI;
            end
            WR_HI: begin
                mem_req_val  = mem_req_rdy & ~rst;
                mem_req_rw   = 1'b1;
                mem_req_data = line_q[255:128];
                if (mem_req_rdy) state_d = IDLE;
            end
            RD_REQ: begin
                mem_req_val = 1'b1;
                if (mem_req_rdy) begin
                    wait_d  = '0;
                    state_d = RD_B0;
                end
            end
            RD_B0: begin
                if (mem_resp_val) begin
                    line_d[127:0] = mem_resp_data;
                    state_d       = RD_B1;
                end else if (wait_q == TMO_LIMIT) begin
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 12'd1;
                end
            end
            RD_B1: begin
                if (mem_resp_val) begin
                    line_d[255:128] = mem_resp_data;
                    state_d         = RESP;
                end else if (wait_q == TMO_LIMIT) begin
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 12'd1;
                end
            end
            RESP: begin
                resp_val  = 1'b1;
                resp_data = line_q;
                if (resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_dram_line_xfer.sv
// Randomised and directed bench for dram_line_xfer against a transaction-level model
// of the line protocol; runs with a short read timeout so abort paths are reachable.
module tb_dram_line_xfer;
    import dram_line_xfer_pkg::*;

    localparam int TMO = 8;

    iu_clk_type    gclk;
    logic          rst;
    logic          req_val, req_rdy, req_rw;
    logic [25:0]   req_addr;
    logic [255:0]  req_data;
    logic          resp_val, resp_rdy;
    logic [255:0]  resp_data;
    logic          mem_req_val, mem_req_rw, mem_req_rdy;
    logic [25:0]   mem_req_addr;
    logic [127:0]  mem_req_data;
    logic          mem_resp_val;
    logic [127:0]  mem_resp_data;
    logic          busy, timeout_err;

    dram_line_xfer #(.TIMEOUT_CYCLES(TMO)) dut (
        .gclk(gclk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .mem_req_val(mem_req_val), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_rdy(mem_req_rdy),
        .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial gclk.clk = 1'b0;
    always #5 gclk.clk = ~gclk.clk;

    typedef struct {
        logic [25:0]  addr;
        logic [127:0] data;
        int           cyc;
    } beat_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    beat_t         wr_q[$];
    logic [25:0]   rd_addr_q[$];
    logic [255:0]  resp_q[$];
    logic          tmo_exp = 1'b0;
    int            resp_hold = 0;
    int            resp_wait = 0;
    logic          prev_hold = 1'b0;
    logic [255:0]  prev_data = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge gclk.clk) cyc++;

    // Protocol monitor: collects handshakes and checks write-beat legality and response hold.
    always @(negedge gclk.clk) begin
        if (!rst) begin
            if (mem_req_val && mem_req_rw) check("wr_val_without_rdy", mem_req_rdy, 1'b1);
            if (mem_req_val && mem_req_rdy) begin
                if (mem_req_rw) wr_q.push_back('{mem_req_addr, mem_req_data, cyc});
                else            rd_addr_q.push_back(mem_req_addr);
            end
            if (prev_hold) begin
                check("resp_val_held", resp_val, 1'b1);
                check("resp_data_held", resp_data, prev_data);
            end
            if (resp_val && resp_rdy) resp_q.push_back(resp_data);
            prev_hold = resp_val && !resp_rdy;
            prev_data = resp_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // One clock; resp_rdy follows the current hold policy for a pending response.
    task automatic tick();
        logic hs;
        if (resp_val) begin
            resp_rdy = (resp_wait >= resp_hold);
            resp_wait++;
        end else begin
            resp_rdy = 1'b0;
        end
        hs = resp_val && resp_rdy;
        @(posedge gclk.clk);
        #1;
        if (hs) resp_wait = 0;
    endtask

    task automatic clear_model();
        wr_q.delete();
        rd_addr_q.delete();
        resp_q.delete();
        tmo_exp   = 1'b0;
        resp_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_val = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ctrl", {req_rdy, resp_val, busy, timeout_err, mem_req_val, mem_req_rw}, 6'b100000);
        check("rst_resp_data", resp_data, '0);
        check("rst_mem_req", {mem_req_addr, mem_req_data}, '0);
        clear_model();
    endtask

    task automatic accept(input logic rw, input logic [25:0] addr, input logic [255:0] data);
        int n = 0;
        while (!req_rdy && n < 50) begin
            tick();
            n++;
        end
        check("req_rdy_seen", req_rdy, 1'b1);
        req_val = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
        tick();
        req_val = 1'b0; req_data = rand256(); req_addr = 26'($urandom);
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic do_write(input logic [25:0] addr, input logic [255:0] data,
                            input int d_lo, input int d_hi);
        beat_t b0, b1;
        wr_q.delete();
        accept(1'b1, addr, data);
        repeat (d_lo) begin mem_req_rdy = 1'b0; tick(); end
        mem_req_rdy = 1'b1; tick();
        repeat (d_hi) begin mem_req_rdy = 1'b0; tick(); end
        mem_req_rdy = 1'b1; tick();
        mem_req_rdy = 1'b0;
        check("wr_beat_count", wr_q.size(), 2);
        if (wr_q.size() >= 2) begin
            b0 = wr_q.pop_front();
            b1 = wr_q.pop_front();
            check("wr_lo_addr", b0.addr, addr);
            check("wr_lo_data", b0.data, data[127:0]);
            check("wr_hi_addr", b1.addr, addr);
            check("wr_hi_data", b1.data, data[255:128]);
            check("wr_beat_spacing", b1.cyc - b0.cyc, d_hi + 1);
        end
        check("wr_done_req_rdy", req_rdy, 1'b1);
    endtask

    // Beats arrive after g0 and then g1 idle cycles; the read aborts at the idle cycle
    // that finds TMO idle cycles already elapsed, unless a beat lands in that cycle.
    task automatic do_read(input logic [25:0] addr, input int rq_d, input int g0, input int g1,
                           input logic [127:0] d0, input logic [127:0] d1, input int hold);
        logic [255:0] exp;
        logic         to;
        int           n = 0;
        resp_hold = hold;
        rd_addr_q.delete();
        accept(1'b0, addr, rand256());
        repeat (rq_d) begin mem_req_rdy = 1'b0; tick(); end
        mem_req_rdy = 1'b1; tick();
        mem_req_rdy = 1'b0;
        check("rd_req_count", rd_addr_q.size(), 1);
        if (rd_addr_q.size() > 0) check("rd_req_addr", rd_addr_q.pop_front(), addr);

        repeat (g0) tick();
        mem_resp_val = 1'b1; mem_resp_data = d0; tick();
        mem_resp_val = 1'b0; mem_resp_data = 128'($urandom);
        repeat (g1) tick();
        mem_resp_val = 1'b1; mem_resp_data = d1; tick();
        mem_resp_val = 1'b0; mem_resp_data = 128'($urandom);

        exp = '0;
        to  = 1'b0;
        if (g0 <= TMO) begin
            exp[127:0] = d0;
            if (g0 + g1 <= TMO) exp[255:128] = d1;
            else                to = 1'b1;
        end else begin
            to = 1'b1;
        end
        if (rq_d == 0 && g0 == 0 && g1 == 0) check("rd_min_latency", resp_val, 1'b1);

        while (resp_q.size() == 0 && n < 64) begin
            tick();
            n++;
        end
        check("rd_resp_count", resp_q.size(), 1);
        if (resp_q.size() > 0) check("rd_resp_data", resp_q.pop_front(), exp);
        tmo_exp = tmo_exp | to;
        check("timeout_err", timeout_err, tmo_exp);
        check("rd_done_idle", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_val = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
        resp_rdy = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
        @(posedge gclk.clk); #1;
        do_reset();

        do_write(26'h0000123, {128'hB, 128'hA}, 0, 0);
        do_write(26'h1234567, rand256(), 5, 5);

        do_read(26'h3FFFFFF, 0, 0, 1, 128'h11, 128'h22, 3);
        do_read(26'h0000042, 0, 0, 0, 128'h77, 128'h88, 0);
        do_read(26'h0000abc, 1, 3, 5, 128'h33, 128'h44, 1);

        repeat (2) begin
            mem_resp_val = 1'b1; mem_resp_data = 128'hDEAD;
            tick();
            check("spurious_no_resp", resp_val, 1'b0);
            check("spurious_idle", busy, 1'b0);
        end
        mem_resp_val = 1'b0;
        do_read(26'h0000555, 0, 1, 0, 128'h66, 128'h99, 0);

        do_read(26'h0000777, 0, 0, 20, 128'h55, 128'h5A, 0);
        do_read(26'h0000778, 0, 0, 0, 128'h12, 128'h34, 0);
        do_read(26'h0000779, 0, 9, 0, 128'hAA, 128'hBB, 2);

        wr_q.delete();
        accept(1'b1, 26'h0000999, rand256());
        mem_req_rdy = 1'b1; tick();
        mem_req_rdy = 1'b0; rst = 1'b1; req_val = 1'b1; req_rw = 1'b1;
        tick();
        rst = 1'b0; req_val = 1'b0; mem_req_rdy = 1'b1;
        #1;
        check("rst_wrhi_val", mem_req_val, 1'b0);
        check("rst_wrhi_idle", busy, 1'b0);
        check("rst_wrhi_tmo", timeout_err, 1'b0);
        repeat (3) tick();
        mem_req_rdy = 1'b0;
        check("rst_wrhi_beats", wr_q.size(), 1);
        clear_model();

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                mem_resp_val = 1'b1; mem_resp_data = 128'($urandom);
                tick();
                mem_resp_val = 1'b0;
            end
            if ($urandom_range(0, 1) == 1)
                do_write(26'($urandom), rand256(), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(26'($urandom), $urandom_range(0, 3), $urandom_range(0, 6),
                        $urandom_range(0, 6), 128'($urandom), 128'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_line_xfer.md
DRAM_LINE_XFER -- requirements
Module: dram_line_xfer

Purpose: converts 256-bit (32-byte) cache-line read/write requests into the 128-bit two-beat memory-controller request/response protocol; sits directly upstream of the memory-controller interface.

Interface
Parameters: one per line (name, default, meaning).
REQ-001 SHALL provide TIMEOUT_CYCLES, default 4095: the maximum number of cycles spent waiting for read beats before aborting the read.

Ports: one per line (name, direction, width, meaning).
REQ-002 SHALL provide gclk, input, iu_clk_type: clock; all logic samples on posedge gclk.clk, and this is the only clock.
REQ-003 SHALL provide rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL provide req_val, input, 1: line request valid.
REQ-005 SHALL provide req_rdy, output, 1: request accepted when req_val & req_rdy.
REQ-006 SHALL provide req_rw, input, 1: 1 = write, 0 = read.
REQ-007 SHALL provide req_addr, input, 26: line address.
REQ-008 SHALL provide req_data, input, 256: write line data.
REQ-009 SHALL provide resp_val, output, 1: read line available.
REQ-010 SHALL provide resp_rdy, input, 1: consumer accepts the read line.
REQ-011 SHALL provide resp_data, output, 256: read line data.
REQ-012 SHALL provide mem_req_val, mem_req_rw, mem_req_addr (26) and mem_req_data (128), all outputs: the memory-controller request.
REQ-013 SHALL provide mem_req_rdy, input, 1: the memory-controller request ready.
REQ-014 SHALL provide mem_resp_val, input, 1 and mem_resp_data, input, 128: the memory-controller read beats; these have no backpressure.
REQ-015 SHALL provide busy, output, 1: high whenever the FSM is not in IDLE.
REQ-016 SHALL provide timeout_err, output, 1: sticky read-timeout flag.

Function
REQ-017 SHALL implement the FSM states IDLE, WR_LO, WR_HI, RD_REQ, RD_B0, RD_B1 and RESP.
REQ-018 SHALL assert req_rdy only in IDLE, with no combinational dependence on req_val; on acceptance, register addr, rw and data; go to WR_LO if rw=1, otherwise RD_REQ.
REQ-019 SHALL keep at most one transaction in flight.
REQ-020 SHALL drive mem_req_addr from the registered addr in every non-IDLE state.
REQ-021 SHALL, in WR_LO, drive mem_req_val = mem_req_rdy, mem_req_rw = 1 and mem_req_data = line[127:0]; go to WR_HI on mem_req_rdy.
REQ-022 SHALL, in WR_HI, drive the same signals with line[255:128]; go to IDLE on mem_req_rdy.
REQ-023 SHALL never assert mem_req_val with rw=1 while mem_req_rdy=0, because the controller counts write beats on val&rw regardless of rdy.
REQ-024 SHALL issue no read request between the two beats of a write.
REQ-025 SHALL generate no response for writes; the next request is accepted the cycle after WR_HI completes.
REQ-026 SHALL, in RD_REQ, hold mem_req_val = 1 and mem_req_rw = 0 until mem_req_rdy, then go to RD_B0.
REQ-027 SHALL drive mem_req_val = 0 in IDLE, RD_B0, RD_B1 and RESP.
REQ-028 SHALL, in RD_B0, capture mem_resp_data into line[127:0] on mem_resp_val and go to RD_B1.
REQ-029 SHALL, in RD_B1, capture mem_resp_data into line[255:128] on mem_resp_val and go to RESP.
REQ-030 SHALL, in RESP, assert resp_val = 1 with resp_data = line, holding both stable until resp_rdy; go to IDLE in the resp_rdy cycle.
REQ-031 SHALL have a minimum read latency of 4 cycles from request acceptance to resp_val, assuming rdy and beats arrive immediately.
REQ-032 SHALL ignore and drop any mem_resp_val seen outside RD_B0/RD_B1.
REQ-033 SHALL clear a 12-bit wait counter on entry to RD_B0 and increment it each cycle in RD_B0/RD_B1 without mem_resp_val.
REQ-034 SHALL, when the wait counter equals TIMEOUT_CYCLES, set timeout_err, go to RESP and present the partial line, with uncaptured halves reading 0.
REQ-035 SHALL give a beat arriving in the same cycle as the timeout priority: it is captured and the normal transition is taken.
REQ-036 SHALL clear timeout_err only on rst.
REQ-037 SHALL clear the line buffer to 0 on each accepted read.

Reset
REQ-038 SHALL, while rst=1, put the FSM in IDLE and clear line, addr, wait counter and timeout_err to 0; req_rdy=1 during reset is not acceptance, so no request is captured.
REQ-039 SHALL have all outputs at 0 on the first cycle after rst deasserts, except req_rdy=1.
REQ-040 SHALL abandon any in-progress transaction on rst, with no further mem_req beats; rst is shared with the memory controller, so its write-beat pairing resets together.

Verification
REQ-041 SHALL cover: write addr 0x0000123, data {128'hB, 128'hA}, mem_req_rdy=1 -> beats in consecutive cycles carry 0xA then 0xB, rw=1, addr 0x0000123, then req_rdy=1.
REQ-042 SHALL cover: write with mem_req_rdy low 5 cycles before each beat -> mem_req_val never high while rdy=0, exactly 2 val&rw pulses.
REQ-043 SHALL cover: read addr 0x3FFFFFF with beats 0x11 and 0x22 two cycles apart, resp_rdy=0 for 3 cycles -> resp_data={0x22,0x11} held stable, one resp_val handshake.
REQ-044 SHALL cover: read with TIMEOUT_CYCLES=8 and only one beat 0x55 -> timeout_err=1 after 8 idle cycles, resp_data={0,0x55}; a subsequent read still completes.
REQ-045 SHALL cover: rst asserted in WR_HI -> next cycle IDLE, mem_req_val=0, no second beat, timeout_err=0.
REQ-046 SHALL cover: spurious mem_resp_val in IDLE -> no resp_val, and a following read returns only its own beats.
